// File: rtl/bcd_score_display.sv
// BCD game score counter with win flag, high-score register and 4-digit 7-segment multiplexer.
// Optional feature: define SCORE_LZ_BLANK_EN to blank leading zeros of the displayed value.
module bcd_score_display #(
    parameter int NUM_DIGITS = 2,
    parameter int WIN_SCORE  = 10,
    parameter int STROBE_DIV = 100000
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    INC,
    input  logic                    CLEAR,
    input  logic                    SHOW_HIGH,
    output logic [4*NUM_DIGITS-1:0] SCORE,
    output logic [4*NUM_DIGITS-1:0] HIGH_SCORE,
    output logic                    GAME_WON,
    output logic [3:0]              SEG_SELECT,
    output logic [6:0]              DEC_OUT
);

    localparam int SW = 4 * NUM_DIGITS;
    localparam int PW = $clog2(STROBE_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(STROBE_DIV - 1);

    function automatic logic [SW-1:0] to_bcd(input int value);
        logic [SW-1:0] r;
        int            t;
        r = '0;
        t = value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [SW-1:0]         score_q, score_d;
    logic [SW-1:0]         high_q, high_d;
    logic                  won_q, won_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [1:0]            idx_q, idx_d;
    logic [3:0]            seg_sel_q, seg_sel_d;
    logic [6:0]            dec_q, dec_d;

    logic [NUM_DIGITS-1:0] carry;
    logic [NUM_DIGITS-1:0] digit_nine;
    logic [SW-1:0]         inc_val;
    logic                  all_nines;

    // Ripple-carry chain: digit gi steps when every lower digit is 9.
    assign all_nines = &digit_nine;
    assign carry[0]  = INC & ~CLEAR & ~won_q & ~all_nines;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_nine[gi] = (score_q[4*gi +: 4] == 4'd9);
            assign inc_val[4*gi +: 4] = !carry[gi]     ? score_q[4*gi +: 4] :
                                        digit_nine[gi] ? 4'd0 :
                                                         score_q[4*gi +: 4] + 4'd1;
            if (gi < NUM_DIGITS - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] & digit_nine[gi];
            end
        end
    endgenerate

    always_comb begin
        score_d = score_q;
        won_d   = won_q;
        if (CLEAR) begin
            score_d = '0;
            won_d   = 1'b0;
        end else if (carry[0]) begin
            score_d = inc_val;
            if (WIN_SCORE != 0 && inc_val == WIN_BCD) begin
                won_d = 1'b1;
            end
        end
        high_d = (score_q > high_q) ? score_q : high_q;
    end

    // Display position sequencing.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
    end

    logic [15:0] sel_pad;
    logic [3:0]  digit_cur;
    logic        pos_unused;
    logic        lz_blank;

    always_comb begin
        sel_pad         = '0;
        sel_pad[SW-1:0] = SHOW_HIGH ? high_q : score_q;
    end

    assign digit_cur  = sel_pad[{idx_q, 2'b00} +: 4];
    assign pos_unused = ({30'd0, idx_q} >= 32'(NUM_DIGITS));

`ifdef SCORE_LZ_BLANK_EN
    logic [3:0] upper_nz;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lz
            assign upper_nz[gi] = |sel_pad[15:4*gi];
        end
    endgenerate
    // Digit 0 is never blanked so a zero value still shows a single "0".
    assign lz_blank = (idx_q != 2'd0) && !upper_nz[idx_q];
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        seg_sel_d = ~(4'b0001 << idx_q);
        dec_d     = (pos_unused || lz_blank) ? 7'h7F : seg_decode(digit_cur);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            score_q   <= '0;
            high_q    <= '0;
            won_q     <= 1'b0;
            presc_q   <= '0;
            idx_q     <= 2'd0;
            seg_sel_q <= 4'b1111;
            dec_q     <= 7'h7F;
        end else begin
            score_q   <= score_d;
            high_q    <= high_d;
            won_q     <= won_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            seg_sel_q <= seg_sel_d;
            dec_q     <= dec_d;
        end
    end

    assign SCORE      = score_q;
    assign HIGH_SCORE = high_q;
    assign GAME_WON   = won_q;
    assign SEG_SELECT = seg_sel_q;
    assign DEC_OUT    = dec_q;

endmodule

// File: doc/bcd_score_display.md
# bcd_score_display

Parametrised game score block: a NUM_DIGITS-wide BCD score counter with configurable win threshold, a high-score register and a built-in time-multiplexed driver for the 4-digit 7-segment display. Sits between the game FSM (which pulses INC when the snake eats a target and CLEAR on a new game) and the board display pins. It generalises the fixed two-digit, win-at-10 score counter, adds score saturation, a high-score view and an optional leading-zero blanking mode.

## Interface
Parameters:
- NUM_DIGITS, 2: score digits, legal 1..4; display positions at or above NUM_DIGITS are blank.
- WIN_SCORE, 10: decimal score that asserts GAME_WON; 0 disables win detection; must be ≤ 10^NUM_DIGITS − 1.
- STROBE_DIV, 100000: CLK cycles per display position (100 MHz → 1 kHz refresh); ≥ 2.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- INC  input  1  one-cycle increment pulse; level held N cycles counts N times.
- CLEAR  input  1  synchronous score clear; high score kept.
- SHOW_HIGH  input  1  1 = display high score, 0 = display current score.
- SCORE  output  4*NUM_DIGITS  current score, packed BCD, digit 0 in [3:0].
- HIGH_SCORE  output  4*NUM_DIGITS  best score since reset, packed BCD.
- GAME_WON  output  1  sticky win flag.
- SEG_SELECT  output  4  anode enables, active-low, bit 0 = rightmost.
- DEC_OUT  output  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- Score: ripple-carry BCD chain; digit i increments when INC and digits 0..i−1 all equal 9; digits at 9 roll to 0.
- Saturation: at 10^NUM_DIGITS − 1 (all 9s) INC is ignored; no wrap to 0.
- Win: GAME_WON sets when the next SCORE equals WIN_SCORE (BCD-encoded); once set, INC is ignored and SCORE holds; GAME_WON clears only on CLEAR or RESET.
- CLEAR: SCORE ← 0, GAME_WON ← 0. CLEAR and INC in the same cycle: CLEAR wins, INC dropped.
- High score: each cycle, if SCORE > HIGH_SCORE (unsigned compare of packed BCD) then HIGH_SCORE ← SCORE. Unaffected by CLEAR.
- Display: prescaler counts 0..STROBE_DIV−1; on terminal count the 2-bit position index advances 0→1→2→3→0. Selected value = SHOW_HIGH ? HIGH_SCORE : SCORE. For the current index p: if p ≥ NUM_DIGITS, SEG_SELECT bit p low with DEC_OUT = 7'h7F (blank); else decode digit p (0 = 7'b1000000, 1 = 7'b1111001, … 9 = 7'b0010000). Exactly one SEG_SELECT bit low at any time after first refresh.
- BCD digit values 10..15 cannot occur; decoder maps them to blank.

## Timing
- Reset (RESET low, asynchronous): SCORE 0, HIGH_SCORE 0, GAME_WON 0, prescaler 0, index 0, SEG_SELECT 4'b1111, DEC_OUT 7'h7F.
- SEG_SELECT/DEC_OUT are registered: updated on the edge after the index or selected value changes (1-cycle latency). First edge after RESET release drives SEG_SELECT 4'b1110.
- INC sampled at edge k → SCORE new value visible after edge k; GAME_WON asserts on the same edge as SCORE reaches WIN_SCORE.
- HIGH_SCORE follows SCORE one cycle later.
- SHOW_HIGH change reflected on DEC_OUT one cycle later; not synchronised internally (driven from CLK domain).
- Each display position held exactly STROBE_DIV cycles; full refresh 4*STROBE_DIV cycles.
- RESET assertion mid-count or mid-strobe: all state returns to reset values immediately, no partial update.

## Configuration
- SCORE_LZ_BLANK_EN: when defined, leading zero digits of the displayed value are blanked (digit p blank if p > 0 and all digits ≥ p are 0; digit 0 always shown, so score 0 shows a single "0"). When undefined, all NUM_DIGITS digits are shown with leading zeros. SCORE, HIGH_SCORE and GAME_WON unaffected.

## Test plan
- Reset: hold RESET low with INC toggling → SCORE 0, GAME_WON 0, SEG_SELECT 4'b1111, DEC_OUT 7'h7F; release → SEG_SELECT 4'b1110, DEC_OUT 7'b1000000.
- Carry and win (NUM_DIGITS 2, WIN_SCORE 10): 9 INC pulses → SCORE 8'h09; 10th → SCORE 8'h10, GAME_WON 1 same cycle; 3 more INC → SCORE stays 8'h10.
- Saturation (NUM_DIGITS 2, WIN_SCORE 0): 105 INC pulses → SCORE 8'h99, GAME_WON 0.
- CLEAR priority and high score: score 7, assert CLEAR+INC together → SCORE 0, GAME_WON 0, HIGH_SCORE 8'h07; SHOW_HIGH 1 → digit 0 shows 7'b1111000.
- Multiplex (STROBE_DIV 4, NUM_DIGITS 2, score 8'h35): SEG_SELECT cycles 1110,1101,1011,0111 every 4 cycles; DEC_OUT 7'b0010010, 7'b0110000, 7'h7F, 7'h7F.
- Blanking (SCORE_LZ_BLANK_EN, NUM_DIGITS 3, score 12'h005): position 1 and 2 show 7'h7F, position 0 shows 7'b0010010; without macro position 1,2 show 7'b1000000.
